reg_pattern_player: RTL

//  Parametrised ROWSxCOLS pattern source for the LED-matrix game. For the row

---
 rtl/reg_pattern_player.sv | 137 +++++++++++++
 1 files changed

// File: rtl/reg_pattern_player.sv
// reg_pattern_player
// Column-word source for the LED matrix. For the row selected by indice it
// produces OFF, ALL_ON or the "V" victory row, and it can play a timed
// level-pass animation that alternates victory and all-on frames.
module reg_pattern_player #(
    parameter int ROWS            = 8,
    parameter int COLS            = 8,
    parameter int FRAMES          = 4,
    parameter int TICKS_PER_FRAME = 50
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]    indice,
    input  logic [1:0]                                    modo,
    input  logic                                          start,
    input  logic                                          abort,
    output logic [COLS-1:0]                               coluna_sel,
    output logic                                          busy,
    output logic                                          done,
    output logic [((FRAMES > 1) ? $clog2(FRAMES) : 1)-1:0] frame_idx
);

    localparam int IDX_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FRM_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int TICK_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;

    localparam logic [1:0] MODO_OFF    = 2'd0;
    localparam logic [1:0] MODO_ALL_ON = 2'd1;
    localparam logic [1:0] MODO_ANIM   = 2'd3;

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICKS_PER_FRAME - 1);
    localparam logic [FRM_W-1:0]  FRAME_LAST = FRM_W'(FRAMES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [FRM_W-1:0]    frame_q, frame_d;
    logic                done_q, done_d;
    logic [COLS-1:0]     coluna_q, coluna_d;

    // The "V" opens outward by one column every two rows, clamped to the edges.
    function automatic logic [COLS-1:0] victoryRow(input logic [IDX_W-1:0] r);
        int c1;
        int c2;
        logic [COLS-1:0] row;
        c1 = COLS / 2 + int'(r) / 2;
        if (c1 > COLS - 1) c1 = COLS - 1;
        c2 = COLS / 2 - 1 - int'(r) / 2;
        if (c2 < 0) c2 = 0;
        row = '0;
        for (int c = 0; c < COLS; c++) begin
            row[c] = (c == c1) || (c == c2);
        end
        return row;
    endfunction

    // Animation sequencing: start only from IDLE in ANIM mode, abort wins over the final wrap.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        frame_d = frame_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (modo == MODO_ANIM)) begin
                    state_d = PLAY;
                    tick_d  = '0;
                    frame_d = '0;
                end
            end
            PLAY: begin
                if (abort) begin
                    state_d = IDLE;
                    tick_d  = '0;
                    frame_d = '0;
                end else if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (frame_q != FRAME_LAST) begin
                        frame_d = frame_q + FRM_W'(1);
                    end else begin
                        state_d = IDLE;
                        frame_d = '0;
                        done_d  = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = '0;
                frame_d = '0;
            end
        endcase
    end

    // Column word chosen from the pre-edge mode, state and frame, registered below.
    always_comb begin
        coluna_d = '0;
        if (state_q == PLAY) begin
            coluna_d = frame_q[0] ? '1 : victoryRow(indice);
        end else begin
            case (modo)
                MODO_OFF:    coluna_d = '0;
                MODO_ALL_ON: coluna_d = '1;
                default:     coluna_d = victoryRow(indice);
            endcase
        end
    end

    // State, counters and the registered column word; reset drops everything immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            frame_q  <= '0;
            done_q   <= 1'b0;
            coluna_q <= '0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            frame_q  <= frame_d;
            done_q   <= done_d;
            coluna_q <= coluna_d;
        end
    end

    assign coluna_sel = coluna_q;
    assign busy       = (state_q == PLAY);
    assign done       = done_q;
    assign frame_idx  = frame_q;

endmodule
